// File: rtl/inst_fetch_if.sv
// Read port toward the instruction buffer plus the valid/ready link to the decoder.
// master = fetcher side, slave = buffer/decoder side.
interface inst_fetch_if;
    logic [11:0]  o_inst_raddr;
    logic         o_inst_rd_en;
    logic [127:0] i_inst_rdat;
    logic         i_inst_rdat_vld;
    logic [127:0] o_inst;
    logic [11:0]  o_inst_addr;
    logic         o_inst_vld;
    logic         i_inst_rdy;

    modport master (
        output o_inst_raddr, o_inst_rd_en,
        input  i_inst_rdat, i_inst_rdat_vld,
        output o_inst, o_inst_addr, o_inst_vld,
        input  i_inst_rdy
    );

    modport slave (
        input  o_inst_raddr, o_inst_rd_en,
        output i_inst_rdat, i_inst_rdat_vld,
        input  o_inst, o_inst_addr, o_inst_vld,
        output i_inst_rdy
    );
endinterface

// File: rtl/inst_fetch.sv
// Sequential instruction fetcher: issues N buffer reads under a credit limit, absorbs the
// read latency in a small first-word-fall-through FIFO and hands words to the decoder.
module inst_fetch #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [11:0] i_start_addr,
    input  logic [12:0] i_inst_num,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    inst_fetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FLUSH} state_t;

    state_t        state_q, state_d;
    logic [11:0]   addr_q, addr_d;
    logic [12:0]   remain_q, remain_d;
    logic          zero_done_q, zero_done_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [127:0]  data_mem_q [FIFO_DEPTH];
    logic [11:0]   addr_mem_q [FIFO_DEPTH];
    logic [11:0]   shadow_q   [RD_LAT];

    logic          strobe, capture, push, pop, rd_en;
    logic          drain_done, abort_now, in_prog, fifo_vld;
    logic [CW:0]   credit_used;

    // Align the buffer's valid with its data for the REG_OUT build.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign strobe = bus.i_inst_rdat_vld;
        end else begin : g_latn
            logic [RD_LAT-2:0] vld_pipe_q;
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    vld_pipe_q <= '0;
                end else begin
                    vld_pipe_q[0] <= bus.i_inst_rdat_vld;
                    for (int i = 1; i < RD_LAT - 1; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
                end
            end
            assign strobe = vld_pipe_q[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) shadow_q[i] <= '0;
        end else begin
            shadow_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) shadow_q[i] <= shadow_q[i-1];
        end
    end

    assign in_prog     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign abort_now   = in_prog && i_abort;
    assign credit_used = {1'b0, cnt_q} + {1'b0, inflight_q};
    assign rd_en       = (state_q == S_FETCH) && !i_abort && (remain_q != '0)
                         && (credit_used < (CW+1)'(FIFO_DEPTH));
    // Strobes with nothing outstanding are leftovers from before a reset.
    assign capture     = strobe && (inflight_q != '0);
    assign push        = capture && in_prog && !i_abort;
    assign fifo_vld    = (cnt_q != '0);
    assign pop         = fifo_vld && bus.i_inst_rdy;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        zero_done_d = 1'b0;
        drain_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d   = i_start_addr;
                    remain_d = i_inst_num;
                    if (i_inst_num == '0) zero_done_d = 1'b1;
                    else                  state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_abort) begin
                    state_d = S_FLUSH;
                end else if (rd_en) begin
                    addr_d   = addr_q + 12'd1;
                    remain_d = remain_q - 13'd1;
                    if (remain_q == 13'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    state_d = S_FLUSH;
                end else if ((cnt_q == '0) && (inflight_q == '0)) begin
                    drain_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (inflight_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q + CW'(rd_en) - CW'(capture);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (abort_now) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            zero_done_q <= 1'b0;
            inflight_q  <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            zero_done_q <= zero_done_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= bus.i_inst_rdat;
            addr_mem_q[wr_ptr_q] <= shadow_q[RD_LAT-1];
        end
    end

    assign bus.o_inst_raddr = addr_q;
    assign bus.o_inst_rd_en = rd_en;
    assign bus.o_inst_vld   = fifo_vld;
    assign bus.o_inst       = fifo_vld ? data_mem_q[rd_ptr_q] : '0;
    assign bus.o_inst_addr  = fifo_vld ? addr_mem_q[rd_ptr_q] : '0;
    assign o_busy           = (state_q != S_IDLE);
    assign o_done           = zero_done_q | drain_done;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: RD_LAT=1 and RD_LAT=2 instances run side by side
// against a behavioural buffer model and an always-ready/stallable decoder.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] start_addr = '0;
    logic [12:0] inst_num = '0;
    logic        abort = 1'b0;
    logic        rdy = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         busy_w  [2];
    logic         done_w  [2];
    logic         rd_en_w [2];
    logic [11:0]  raddr_w [2];
    logic         vld_w   [2];
    logic [127:0] inst_w  [2];
    logic [11:0]  iaddr_w [2];

    function automatic logic [127:0] word_of(input logic [11:0] a);
        return {4{20'hF00D0, a}};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = gi + 1;
        inst_fetch_if bus ();
        logic [127:0] d1_q = '0;
        logic [127:0] d2_q = '0;
        logic         vld_q = 1'b0;

        inst_fetch #(.RD_LAT(LAT), .FIFO_DEPTH(4)) dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_start      (start),
            .i_start_addr (start_addr),
            .i_inst_num   (inst_num),
            .i_abort      (abort),
            .o_busy       (busy_w[gi]),
            .o_done       (done_w[gi]),
            .bus          (bus)
        );

        always @(posedge clk) begin
            vld_q <= bus.o_inst_rd_en;
            if (bus.o_inst_rd_en) d1_q <= word_of(bus.o_inst_raddr);
            d2_q <= d1_q;
        end
        assign bus.i_inst_rdat     = (LAT == 1) ? d1_q : d2_q;
        assign bus.i_inst_rdat_vld = vld_q;
        assign bus.i_inst_rdy      = rdy;

        assign rd_en_w[gi] = bus.o_inst_rd_en;
        assign raddr_w[gi] = bus.o_inst_raddr;
        assign vld_w[gi]   = bus.o_inst_vld;
        assign inst_w[gi]  = bus.o_inst;
        assign iaddr_w[gi] = bus.o_inst_addr;
    end

    // Transaction logs filled at the falling edge.
    int           rd_n [2] = '{0, 0};
    int           acc_n[2] = '{0, 0};
    int           done_n[2] = '{0, 0};
    int           viol [2] = '{0, 0};
    int           done_cyc[2];
    logic [11:0]  rd_log  [2][256];
    int           rd_cyc  [2][256];
    logic [11:0]  acc_addr[2][256];
    logic [127:0] acc_dat [2][256];
    int           acc_cyc [2][256];
    logic         pv[2] = '{1'b0, 1'b0};
    logic [127:0] pd[2];
    logic [11:0]  pa[2];
    logic         pr = 1'b0;
    logic         p_clr = 1'b1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en_w[i] === 1'b1) begin
                rd_log[i][rd_n[i] % 256] = raddr_w[i];
                rd_cyc[i][rd_n[i] % 256] = cyc;
                rd_n[i]++;
            end
            if (vld_w[i] === 1'b1 && rdy) begin
                acc_addr[i][acc_n[i] % 256] = iaddr_w[i];
                acc_dat[i][acc_n[i] % 256]  = inst_w[i];
                acc_cyc[i][acc_n[i] % 256]  = cyc;
                acc_n[i]++;
            end
            if (done_w[i] === 1'b1) begin
                done_cyc[i] = cyc;
                done_n[i]++;
            end
            if (pv[i] && !pr && !p_clr &&
                (vld_w[i] !== 1'b1 || inst_w[i] !== pd[i] || iaddr_w[i] !== pa[i]))
                viol[i]++;
            pv[i] = (vld_w[i] === 1'b1);
            pd[i] = inst_w[i];
            pa[i] = iaddr_w[i];
        end
        pr    = rdy;
        p_clr = abort || !rst_n;
    end

    int r0[2], c0[2], dn0[2];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            r0[i]  = rd_n[i];
            c0[i]  = acc_n[i];
            dn0[i] = done_n[i];
        end
    endtask

    task automatic start_prog(input logic [11:0] a, input logic [12:0] n);
        snap();
        start      = 1'b1;
        start_addr = a;
        inst_num   = n;
        start_cyc  = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy_w[0] || busy_w[1]) && k < budget) begin
            step();
            k++;
        end
        chk(tag, 128'(k < budget), 128'(1));
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s%0d ctl", tag, i),
                {busy_w[i], done_w[i], rd_en_w[i], vld_w[i], raddr_w[i], iaddr_w[i]}, '0);
            chk($sformatf("%s%0d inst", tag, i), inst_w[i], '0);
        end
    endtask

    task automatic chk_prog(input string tag, input logic [11:0] a0, input int num);
        for (int i = 0; i < 2; i++) begin
            int bad_r = 0, bad_a = 0, bad_d = 0;
            logic [11:0] e;
            chk($sformatf("%s%0d rd_cnt", tag, i), rd_n[i] - r0[i], num);
            chk($sformatf("%s%0d acc_cnt", tag, i), acc_n[i] - c0[i], num);
            chk($sformatf("%s%0d done_cnt", tag, i), done_n[i] - dn0[i], 1);
            for (int k = 0; k < num; k++) begin
                e = a0 + 12'(k);
                if (rd_log[i][(r0[i] + k) % 256] !== e) bad_r++;
                if (acc_addr[i][(c0[i] + k) % 256] !== e) bad_a++;
                if (acc_dat[i][(c0[i] + k) % 256] !== word_of(e)) bad_d++;
            end
            chk($sformatf("%s%0d raddr_seq_err", tag, i), bad_r, 0);
            chk($sformatf("%s%0d addr_seq_err", tag, i), bad_a, 0);
            chk($sformatf("%s%0d data_err", tag, i), bad_d, 0);
        end
    endtask

    initial begin
        step(2);
        chk_zero("reset");
        rst_n = 1'b1;
        rdy   = 1'b1;
        step();

        // Basic program: timing of reads, first word and done pulse
        start_prog(12'h010, 13'd8);
        wait_idle("t1 idle", 60);
        chk_prog("t1 ", 12'h010, 8);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t1 %0d first_rd_cyc", i), rd_cyc[i][r0[i] % 256], start_cyc + 1);
            chk($sformatf("t1 %0d rd_span", i),
                rd_cyc[i][(r0[i] + 7) % 256] - rd_cyc[i][r0[i] % 256], 7);
            chk($sformatf("t1 %0d first_acc_cyc", i), acc_cyc[i][c0[i] % 256], start_cyc + i + 3);
            chk($sformatf("t1 %0d done_cyc", i), done_cyc[i], start_cyc + i + 11);
        end

        // Address wrap
        step(2);
        start_prog(12'hFFE, 13'd4);
        wait_idle("t2 idle", 60);
        chk_prog("t2 ", 12'hFFE, 4);

        // Decoder stall: credits cap outstanding reads at the FIFO depth
        step(2);
        start_prog(12'h100, 13'd40);
        step(6);
        rdy = 1'b0;
        step(15);
        begin
            int rs[2];
            rs[0] = rd_n[0];
            rs[1] = rd_n[1];
            step(5);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("t3 %0d rd_stalled", i), rd_n[i] - rs[i], 0);
                chk($sformatf("t3 %0d outstanding", i),
                    (rd_n[i] - r0[i]) - (acc_n[i] - c0[i]), 4);
                chk($sformatf("t3 %0d vld_held", i), vld_w[i], 1'b1);
            end
        end
        rdy = 1'b1;
        wait_idle("t3 idle", 200);
        chk_prog("t3 ", 12'h100, 40);

        // Abort with a word waiting in the FIFO
        step(2);
        rdy = 1'b0;
        start_prog(12'h7F0, 13'd100);
        step(2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("t4 %0d vld_flushed", i), vld_w[i], 1'b0);
        wait_idle("t4 idle", 10);
        step(3);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t4 %0d no_done", i), done_n[i] - dn0[i], 0);
            chk($sformatf("t4 %0d vld_after", i), vld_w[i], 1'b0);
            chk($sformatf("t4 %0d no_accept", i), acc_n[i] - c0[i], 0);
        end
        rdy = 1'b1;
        start_prog(12'h200, 13'd5);
        wait_idle("t4b idle", 60);
        chk_prog("t4b ", 12'h200, 5);

        // Zero-length program
        step(2);
        start_prog(12'h050, 13'd0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5 %0d done", i), done_w[i], 1'b1);
            chk($sformatf("t5 %0d busy", i), busy_w[i], 1'b0);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5 %0d done_low", i), done_w[i], 1'b0);
            chk($sformatf("t5 %0d no_rd", i), rd_n[i] - r0[i], 0);
        end

        // Start while busy is ignored
        step(2);
        start_prog(12'h300, 13'd10);
        step(3);
        start      = 1'b1;
        start_addr = 12'h555;
        inst_num   = 13'd3;
        step();
        start = 1'b0;
        wait_idle("t5b idle", 60);
        chk_prog("t5b ", 12'h300, 10);

        // Reset mid-program, then a clean restart
        step(2);
        start_prog(12'h400, 13'd20);
        step(4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_zero("t6 rst");
        snap();
        step(6);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6 %0d no_output", i), acc_n[i] - c0[i], 0);
            chk($sformatf("t6 %0d vld", i), vld_w[i], 1'b0);
            chk($sformatf("t6 %0d busy", i), busy_w[i], 1'b0);
        end
        start_prog(12'h0A0, 13'd3);
        wait_idle("t6b idle", 60);
        chk_prog("t6b ", 12'h0A0, 3);

        for (int i = 0; i < 2; i++) chk($sformatf("stall_stability %0d", i), viol[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
